isr_arbiter: RTL
================

// Module: isr_arbiter
// PURPOSE
//  Shares one iterative integer-square-root unit (ISR: value[63:0] in, result[31:0] out, done flag,
//  restarted by pulsing its reset) among NUM_REQ requesters. Round-robin arbitration, operand capture,
//  ISR start/wait sequencing, timeout guard, and a single tagged response port back to requesters.
// PARAMETERS
//  NUM_REQ  4     number of requesters, 2..16
//  ID_W     2     width of requester id, = clog2(NUM_REQ)
//  TIMEOUT  1000  max WAIT cycles before abandoning an op, >= 1
// PORTS
//  clock        in   1            single clock, rising edge
//  reset        in   1            asynchronous, active-high
//  req          in   NUM_REQ      level request per requester
//  req_value    in   64*NUM_REQ   operand, requester i at [64*i +: 64]
//  gnt          out  NUM_REQ      one-hot one-cycle grant pulse; operand already captured
//  busy         out  1            high in any state other than IDLE
//  resp_valid   out  1            one-cycle response strobe
//  resp_id      out  ID_W         requester the response belongs to
//  resp_result  out  32           floor(sqrt(operand)); 0 on error
//  resp_err     out  1            op timed out
//  isr_reset    out  1            drives ISR reset; restarts the ISR
//  isr_value    out  64           drives ISR value; stable from START until leaving WAIT
//  isr_result   in   32           ISR result
//  isr_done     in   1            ISR done
// BEHAVIOUR
//  Reset (async assert): state=IDLE, rr_ptr=0, wait_cnt=0, operand=0; gnt=0, busy=0, resp_valid=0,
//   resp_id=0, resp_result=0, resp_err=0, isr_value=0. isr_reset = reset | start_pulse (comb OR),
//   so the ISR is held in reset while the arbiter is.
//  FSM IDLE -> START -> WAIT -> RESP -> IDLE; all outputs registered except isr_reset.
//  IDLE: if any req bit high, select first set bit scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ;
//   capture req_value of winner into operand, id into cur_id; -> START. No req: stay.
//   Only req bits high in this cycle are eligible; a request dropped before sampling is ignored.
//  START (1 cycle): gnt[cur_id]=1, isr_reset=1, isr_value=operand, wait_cnt=0; -> WAIT.
//   Requester must deassert req (or present a new operand) after seeing gnt; req/value are not
//   re-sampled until the next IDLE.
//  WAIT: isr_reset=0, isr_value held. Each cycle: if isr_done -> latch isr_result, -> RESP (err=0);
//   else if wait_cnt==TIMEOUT-1 -> RESP with resp_result=0, resp_err=1; else wait_cnt++.
//   isr_done is honoured from the first WAIT cycle (ISR(0)/ISR(1) may finish immediately).
//   done wins over timeout in the same cycle.
//  RESP (1 cycle): resp_valid=1 with resp_id=cur_id, resp_result, resp_err; rr_ptr=(cur_id+1) mod
//   NUM_REQ; -> IDLE. No back-pressure: requesters must accept the strobe.
//  Latency: req sampled in IDLE cycle c -> gnt in c+1 -> first WAIT c+2; isr_done seen in cycle d
//   -> resp_valid in d+1. Min request-to-response = 3 cycles; back-to-back ops have one IDLE cycle.
//  Fairness: winner of an op has lowest priority next arbitration; no requester starves while others
//   continuously request (worst case NUM_REQ-1 ops ahead).
//  gnt, resp_valid never high in the same cycle; at most one gnt bit high.
//  Reset mid-operation: op abandoned, no response emitted, ISR restarted; requester must re-request.
// TESTING
//  1. Single req[0], value 24 -> gnt=4'b0001 one cycle, later resp_valid, resp_id=0, result=4, err=0.
//  2. req=4'b1111 simultaneously, values 1001/65536/0/1 -> served ids 0,1,2,3 in order,
//     results 31/256/0/1; exactly four resp_valid pulses, gnt one-hot.
//  3. Fairness: req0 and req1 held high continuously after id0 served -> next grant id1, then id0.
//  4. Max operand 64'hFFFF_FFFF_FFFF_FFFF on req2 -> resp_id=2, result=32'hFFFF_FFFF.
//  5. Stub ISR with isr_done tied 0, TIMEOUT=16 -> resp_err=1, result=0, exactly 16 WAIT cycles;
//     next request still served.
//  6. Assert reset in WAIT -> all outputs 0 and isr_reset=1 immediately, no resp_valid; after
//     release, new req[3] value 144 -> result 12.

Source files
------------

// File: rtl/isr_arbiter.sv
// Round-robin arbiter sharing one iterative integer-square-root unit among NUM_REQ requesters.
// Captures the winning operand, restarts the ISR, waits with a timeout guard, and returns a tagged response.
module isr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 1000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [64*NUM_REQ-1:0] req_value,
    output logic [NUM_REQ-1:0]    gnt,
    output logic                  busy,
    output logic                  resp_valid,
    output logic [ID_W-1:0]       resp_id,
    output logic [31:0]           resp_result,
    output logic                  resp_err,
    output logic                  isr_reset,
    output logic [63:0]           isr_value,
    input  logic [31:0]           isr_result,
    input  logic                  isr_done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam int             WCW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);
    localparam logic [ID_W:0]  NREQ      = (ID_W + 1)'(NUM_REQ);

    logic [1:0]         state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    cur_id;
    logic [WCW-1:0]     wait_cnt;

    logic [NUM_REQ-1:0] rot;
    logic               any_req;
    logic [ID_W-1:0]    win_off;
    logic [ID_W:0]      win_sum;
    logic [ID_W-1:0]    win_id;
    logic [NUM_REQ-1:0] win_onehot;
    logic [63:0]        win_value;
    logic [ID_W:0]      nxt_sum;
    logic [ID_W-1:0]    nxt_ptr;

    // Rotate requests so rr_ptr sits at bit 0; the first set bit is the winner's offset.
    always_comb begin
        rot     = NUM_REQ'({req, req} >> rr_ptr);
        any_req = 1'b0;
        win_off = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!any_req && rot[i]) begin
                any_req = 1'b1;
                win_off = ID_W'(i);
            end
        end
        win_sum = {1'b0, rr_ptr} + {1'b0, win_off};
        if (win_sum >= NREQ)
            win_sum = win_sum - NREQ;
        win_id = win_sum[ID_W-1:0];
    end

    always_comb begin
        win_onehot = '0;
        win_value  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == win_id) begin
                win_onehot[i] = any_req;
                win_value     = req_value[64*i +: 64];
            end
        end
    end

    always_comb begin
        nxt_sum = {1'b0, cur_id} + (ID_W + 1)'(1);
        if (nxt_sum >= NREQ)
            nxt_sum = '0;
        nxt_ptr = nxt_sum[ID_W-1:0];
    end

    // The ISR restart is combinational so the ISR is held in reset together with the arbiter.
    assign isr_reset = reset | (state == START);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            cur_id      <= '0;
            wait_cnt    <= '0;
            gnt         <= '0;
            busy        <= 1'b0;
            resp_valid  <= 1'b0;
            resp_id     <= '0;
            resp_result <= '0;
            resp_err    <= 1'b0;
            isr_value   <= '0;
        end else begin
            gnt        <= '0;
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        cur_id    <= win_id;
                        isr_value <= win_value;
                        gnt       <= win_onehot;
                        busy      <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (isr_done) begin
                        resp_valid  <= 1'b1;
                        resp_id     <= cur_id;
                        resp_result <= isr_result;
                        resp_err    <= 1'b0;
                        state       <= RESP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        resp_valid  <= 1'b1;
                        resp_id     <= cur_id;
                        resp_result <= '0;
                        resp_err    <= 1'b1;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    rr_ptr <= nxt_ptr;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
